tick_uart_tx: RTL and testbench

Trigger-paced serial transmitter sitting directly downstream of the tick divider. Accepts a parallel word on a valid/ready handshake, frames it (start bit, data LSB-first, optional parity, stop bits) and shifts one bit per `tick` pulse onto `txd`. At frame start it pulses `tick_clr`, wired to the divider's `nul` input, so bit timing is phase-aligned to data acceptance.

---
 rtl/tick_uart_tx.sv | 129 ++++++++++++
 tb/tb_tick_uart_tx.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/tick_uart_tx.sv
// Tick-paced UART transmitter: frames a parallel word (start, LSB-first data,
// optional parity, stop bits) and shifts one bit per qualifying divider tick.
module tick_uart_tx #(
  parameter int DATA_W     = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  output logic              tick_clr,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              txd,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  // Stop counter value at which the final stop bit is being sent.
  localparam logic STOP_LAST = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t            state_reg, state_next;
  logic [DATA_W-1:0] shift_reg, shift_next;
  logic [CNT_W-1:0]  bit_cnt_reg, bit_cnt_next;
  logic              stop_cnt_reg, stop_cnt_next;
  logic              parity_reg, parity_next;
  logic              tick_clr_reg, tick_clr_next;
  logic              accept;
  logic              tick_q;
  logic [DATA_W:0]   par_chain;

  // Parity is folded from the incoming word so it is ready at acceptance.
  assign par_chain[0] = (PARITY_ODD != 0);
  generate
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_par
      assign par_chain[gi+1] = par_chain[gi] ^ din[gi];
    end
  endgenerate

  assign accept = din_valid & (state_reg == IDLE);
  // The tick_clr cycle's tick belongs to the old divider phase, so drop it.
  assign tick_q = tick & ~tick_clr_reg & (state_reg != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      shift_reg    <= '0;
      bit_cnt_reg  <= '0;
      stop_cnt_reg <= 1'b0;
      parity_reg   <= 1'b0;
      tick_clr_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      shift_reg    <= shift_next;
      bit_cnt_reg  <= bit_cnt_next;
      stop_cnt_reg <= stop_cnt_next;
      parity_reg   <= parity_next;
      tick_clr_reg <= tick_clr_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    shift_next    = shift_reg;
    bit_cnt_next  = bit_cnt_reg;
    stop_cnt_next = stop_cnt_reg;
    parity_next   = parity_reg;
    tick_clr_next = 1'b0;
    txd           = 1'b1;

    case (state_reg)
      IDLE: begin
        txd = 1'b1;
        if (accept) begin
          shift_next    = din;
          bit_cnt_next  = '0;
          stop_cnt_next = 1'b0;
          parity_next   = par_chain[DATA_W];
          tick_clr_next = 1'b1;
          state_next    = START;
        end
      end
      START: begin
        txd = 1'b0;
        if (tick_q) state_next = DATA;
      end
      DATA: begin
        txd = shift_reg[0];
        if (tick_q) begin
          shift_next   = shift_reg >> 1;
          bit_cnt_next = bit_cnt_reg + 1'b1;
          if (bit_cnt_reg == LAST_BIT)
            state_next = (PARITY_EN != 0) ? PARITY : STOP;
        end
      end
      PARITY: begin
        txd = parity_reg;
        if (tick_q) state_next = STOP;
      end
      STOP: begin
        txd = 1'b1;
        if (tick_q) begin
          if (stop_cnt_reg == STOP_LAST) state_next = IDLE;
          else stop_cnt_next = 1'b1;
        end
      end
      default: begin
        txd        = 1'b1;
        state_next = IDLE;
      end
    endcase
  end

  assign tick_clr  = tick_clr_reg;
  assign din_ready = (state_reg == IDLE);
  assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_tick_uart_tx.sv
// Bench for tick_uart_tx: three parameterisations share tick/rst/din; each
// frame's line is compared cycle by cycle against an expected bit sequence.
module tb_tick_uart_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic [7:0] din;
  logic [2:0] dv;
  logic [2:0] clr_w, rdy_w, txd_w, busy_w;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  always #5 clk = ~clk;

  // dut0: 8N1, dut1: 8E2, dut2: 8O1
  tick_uart_tx u_dut0 (
    .clk(clk), .rst(rst), .tick(tick), .tick_clr(clr_w[0]), .din(din),
    .din_valid(dv[0]), .din_ready(rdy_w[0]), .txd(txd_w[0]), .busy(busy_w[0])
  );
  tick_uart_tx #(.STOP_BITS(2), .PARITY_EN(1), .PARITY_ODD(0)) u_dut1 (
    .clk(clk), .rst(rst), .tick(tick), .tick_clr(clr_w[1]), .din(din),
    .din_valid(dv[1]), .din_ready(rdy_w[1]), .txd(txd_w[1]), .busy(busy_w[1])
  );
  tick_uart_tx #(.STOP_BITS(1), .PARITY_EN(1), .PARITY_ODD(1)) u_dut2 (
    .clk(clk), .rst(rst), .tick(tick), .tick_clr(clr_w[2]), .din(din),
    .din_valid(dv[2]), .din_ready(rdy_w[2]), .txd(txd_w[2]), .busy(busy_w[2])
  );

  typedef struct {
    int         idx;
    logic [7:0] word;
    logic [15:0] frame;   // bit j = j-th bit on the line
    int         len;
    bit         clr_tick; // also pulse tick in the tick_clr cycle
    int         mode;     // 0 quiet, 1 random din_valid noise, 2 hold valid with next word
    logic [7:0] hold;
    int         gap;      // 0 = random bit period
  } vec_t;

  vec_t tbl[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int frame_len(input int idx);
    return (idx == 0) ? 10 : (idx == 1) ? 12 : 11;
  endfunction

  // Reference model: line sequence from the framing rules.
  function automatic logic [15:0] build_frame(input int idx, input logic [7:0] w);
    logic [15:0] f;
    int n;
    int ones;
    f = '0;
    n = 1;
    for (int i = 0; i < 8; i++) begin
      f[n] = w[i];
      n++;
    end
    if (idx != 0) begin
      ones = $countones(w);
      f[n] = ((ones % 2) == 1) ^ (idx == 2);
      n++;
    end
    for (int s = 0; s < ((idx == 1) ? 2 : 1); s++) begin
      f[n] = 1'b1;
      n++;
    end
    return f;
  endfunction

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      check("idle_lines", {txd_w, busy_w, clr_w}, {3'b111, 3'b000, 3'b000});
      tick = 1'($urandom_range(0, 1));
      dv   = 3'b000;
      step();
    end
    tick = 1'b0;
  endtask

  task automatic run_frame(input int idx, input logic [7:0] word, input logic [15:0] exp_f,
                           input int len, input bit clr_tick, input int mode,
                           input logic [7:0] hold, input int fixed_gap);
    int clr_seen;
    int gap;
    clr_seen = 0;
    din = word;
    dv[idx] = 1'b1;
    tick = 1'b0;
    check("ready_before", 32'(rdy_w[idx]), 32'd1);
    step();
    check("accept_lines", {txd_w[idx], busy_w[idx], rdy_w[idx], clr_w[idx]}, 4'b0101);
    for (int j = 0; j < len; j++) begin
      gap = (fixed_gap != 0) ? fixed_gap : $urandom_range(1, 4);
      for (int c = 0; c <= gap; c++) begin
        check("bit_txd", 32'(txd_w[idx]), 32'(exp_f[j]));
        check("bit_busy_ready", {busy_w[idx], rdy_w[idx]}, 2'b10);
        if (clr_w[idx]) clr_seen++;
        tick = (c == gap) || (j == 0 && c == 0 && clr_tick);
        if (mode == 0) begin
          dv[idx] = 1'b0;
          din = 8'($urandom);
        end else if (mode == 1) begin
          dv[idx] = 1'($urandom_range(0, 1));
          din = 8'($urandom);
        end else begin
          dv[idx] = 1'b1;
          din = hold;
        end
        step();
      end
    end
    tick = 1'b0;
    if (mode != 2) dv[idx] = 1'b0;
    check("end_lines", {txd_w[idx], busy_w[idx], rdy_w[idx], clr_w[idx]}, 4'b1010);
    check("clr_pulses", clr_seen, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    logic [7:0] w;

    tbl[0] = '{0, 8'hA5, 16'h034A, 10, 1'b0, 0, 8'h00, 3};
    tbl[1] = '{1, 8'h07, 16'h0E0E, 12, 1'b0, 0, 8'h00, 0};
    tbl[2] = '{2, 8'h07, 16'h040E, 11, 1'b1, 0, 8'h00, 0};
    tbl[3] = '{0, 8'h3C, 16'h0278, 10, 1'b0, 1, 8'h00, 0};
    tbl[4] = '{0, 8'h00, 16'h0200, 10, 1'b0, 2, 8'hFF, 0};
    tbl[5] = '{0, 8'hFF, 16'h03FE, 10, 1'b1, 0, 8'h00, 0};
    tbl[6] = '{1, 8'h00, 16'h0C00, 12, 1'b1, 1, 8'h00, 0};
    tbl[7] = '{2, 8'hFF, 16'h07FE, 11, 1'b0, 2, 8'h55, 0};
    tbl[8] = '{2, 8'h55, 16'h06AA, 11, 1'b1, 0, 8'h00, 0};

    // Reset held with valid and tick asserted: nothing may start.
    rst  = 1'b1;
    dv   = 3'b111;
    din  = 8'h5A;
    tick = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_hold", {txd_w, busy_w, clr_w}, {3'b111, 3'b000, 3'b000});
    end
    rst = 1'b0;
    check("rst_release_ready", rdy_w, 3'b111);
    step();
    check("rst_first_accept", {busy_w, clr_w, txd_w}, {3'b111, 3'b111, 3'b000});
    rst  = 1'b1;
    dv   = 3'b000;
    tick = 1'b0;
    step();
    rst = 1'b0;
    check("rst_abort_lines", {txd_w, busy_w, rdy_w, clr_w}, {3'b111, 3'b000, 3'b111, 3'b000});
    idle_cycles(3);

    // Reset during DATA bit 3 of 0x00.
    din   = 8'h00;
    dv[0] = 1'b1;
    step();
    dv[0] = 1'b0;
    check("mid_accept", {busy_w[0], clr_w[0]}, 2'b11);
    for (int k = 0; k < 4; k++) begin
      tick = 1'b0;
      step();
      step();
      tick = 1'b1;
      step();
    end
    tick = 1'b0;
    check("mid_pre_rst", {txd_w[0], busy_w[0]}, 2'b01);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_lines", {txd_w[0], busy_w[0], rdy_w[0], clr_w[0]}, 4'b1010);
    idle_cycles(12);

    // Directed table of frames.
    for (int t = 0; t < 9; t++) begin
      run_frame(tbl[t].idx, tbl[t].word, tbl[t].frame, tbl[t].len, tbl[t].clr_tick,
                tbl[t].mode, tbl[t].hold, tbl[t].gap);
      if (tbl[t].mode != 2) idle_cycles($urandom_range(0, 2));
    end

    // Randomized frames against the framing model.
    for (int r = 0; r < 40; r++) begin
      idx = $urandom_range(0, 2);
      w   = 8'($urandom);
      run_frame(idx, w, build_frame(idx, w), frame_len(idx), 1'($urandom_range(0, 1)),
                $urandom_range(0, 1), 8'h00, 0);
      idle_cycles($urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
